// File: rtl/exec_pkg.sv
// Shared definitions for the fetch run controller: FSM encodings, test index width
// and the default debounce interval.
package exec_pkg;

  localparam int TEST_IDX_W = 3;
  localparam int DEB_CNT_W  = 20;
  localparam logic [DEB_CNT_W-1:0] DEBOUNCE_CYCLES_DEF = 20'd500000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    EWAIT = 2'd3
  } seq_state_e;

endpackage

// File: rtl/exec_sequencer_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter and a registered
// one-cycle pulse on each accepted rising edge.
module btn_debounce
  import exec_pkg::*;
#(
  parameter int                CNT_W           = DEB_CNT_W,
  parameter logic [CNT_W-1:0]  DEBOUNCE_CYCLES = CNT_W'(DEBOUNCE_CYCLES_DEF)
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = DEBOUNCE_CYCLES - CNT_W'(1);

  logic             syncMeta_q, syncLevel_q;
  logic             level_q, level_d;
  logic             levelPrev_q;
  logic             press_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the synced level disagrees with the accepted one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (syncLevel_q != level_q) begin
      if (cnt_q == LAST_CNT) begin
        level_d = syncLevel_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      syncMeta_q  <= 1'b0;
      syncLevel_q <= 1'b0;
      level_q     <= 1'b0;
      levelPrev_q <= 1'b0;
      press_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      syncMeta_q  <= btn_i;
      syncLevel_q <= syncMeta_q;
      level_q     <= level_d;
      levelPrev_q <= level_q;
      press_q     <= level_q & ~levelPrev_q;
      cnt_q       <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/exec_sequencer.sv
// Run controller for instruction fetch: start/continue buttons, test select latch,
// ecall hold. Define STEP_MODE_EN to single-step RUN on each continue press.
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int               CNT_W           = DEB_CNT_W,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = CNT_W'(DEBOUNCE_CYCLES_DEF)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_btn,
  input  logic                  continue_btn,
  input  logic [TEST_IDX_W-1:0] test_sw,
  input  logic                  ecall,
  output logic                  pc_change,
  output logic                  continue_out,
  output logic [TEST_IDX_W-1:0] test_number,
  output logic                  pc_hold,
  output logic [1:0]            state
);

  logic                  startPress, contPress;
  logic [TEST_IDX_W-1:0] swMeta_q, swSync_q;
  seq_state_e            state_q, state_d;
  logic [TEST_IDX_W-1:0] testNum_q, testNum_d;
  logic                  pcChange_q, pcChange_d;
  logic                  contOut_q, contOut_d;
  logic                  hold_q, hold_d;
`ifdef STEP_MODE_EN
  logic                  stepRel_d;
`endif

  btn_debounce #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_startDeb (
    .clock(clock), .reset(reset), .btn_i(start_btn), .press_o(startPress)
  );

  btn_debounce #(.CNT_W(CNT_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_contDeb (
    .clock(clock), .reset(reset), .btn_i(continue_btn), .press_o(contPress)
  );

  // Start always takes priority; contOut_q masks ecall for the cycle after a release.
  always_comb begin
    state_d   = state_q;
    testNum_d = testNum_q;
    contOut_d = 1'b0;
`ifdef STEP_MODE_EN
    stepRel_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (startPress) begin
          state_d   = LOAD;
          testNum_d = swSync_q;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (startPress) begin
          state_d   = LOAD;
          testNum_d = swSync_q;
        end else if (ecall && !contOut_q) begin
          state_d = EWAIT;
`ifdef STEP_MODE_EN
        end else if (contPress) begin
          stepRel_d = 1'b1;
`endif
        end
      end
      EWAIT: begin
        if (startPress) begin
          state_d   = LOAD;
          testNum_d = swSync_q;
        end else if (contPress) begin
          state_d   = RUN;
          contOut_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    pcChange_d = (state_d == LOAD);
    case (state_d)
      LOAD:    hold_d = 1'b0;
`ifdef STEP_MODE_EN
      RUN:     hold_d = !(contOut_d || stepRel_d);
`else
      RUN:     hold_d = 1'b0;
`endif
      default: hold_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      swMeta_q   <= '0;
      swSync_q   <= '0;
      state_q    <= IDLE;
      testNum_q  <= '0;
      pcChange_q <= 1'b0;
      contOut_q  <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      swMeta_q   <= test_sw;
      swSync_q   <= swMeta_q;
      state_q    <= state_d;
      testNum_q  <= testNum_d;
      pcChange_q <= pcChange_d;
      contOut_q  <= contOut_d;
      hold_q     <= hold_d;
    end
  end

  assign pc_change    = pcChange_q;
  assign continue_out = contOut_q;
  assign test_number  = testNum_q;
  assign pc_hold      = hold_q;
  assign state        = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a 4-cycle debounce interval.
module tb_exec_sequencer;

`ifdef STEP_MODE_EN
  localparam logic STEP = 1'b1;
`else
  localparam logic STEP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       start_btn, continue_btn, ecall;
  logic [2:0] test_sw;
  logic       pc_change, continue_out, pc_hold;
  logic [2:0] test_number;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  logic [1:0] stateLog [1:20];
  logic       pcLog    [1:20];
  logic       contLog  [1:20];
  logic       holdLog  [1:20];

  always #5 clock = ~clock;

  exec_sequencer #(.CNT_W(20), .DEBOUNCE_CYCLES(20'd4)) dut (
    .clock(clock), .reset(reset), .start_btn(start_btn), .continue_btn(continue_btn),
    .test_sw(test_sw), .ecall(ecall), .pc_change(pc_change), .continue_out(continue_out),
    .test_number(test_number), .pc_hold(pc_hold), .state(state)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Hold buttons for holdCycles samples, logging outputs over a 20-sample window.
  task automatic applyStimulus(input logic pressStart, input logic pressCont,
                               input int holdCycles, input int ecallDropAt);
    start_btn    = pressStart;
    continue_btn = pressCont;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      stateLog[i] = state;
      pcLog[i]    = pc_change;
      contLog[i]  = continue_out;
      holdLog[i]  = pc_hold;
      if (i == holdCycles) begin
        start_btn    = 1'b0;
        continue_btn = 1'b0;
      end
      if (i == ecallDropAt) ecall = 1'b0;
    end
  endtask

  function automatic int countPc();
    int n = 0;
    for (int i = 1; i <= 20; i++) if (pcLog[i]) n++;
    return n;
  endfunction

  function automatic int countCont();
    int n = 0;
    for (int i = 1; i <= 20; i++) if (contLog[i]) n++;
    return n;
  endfunction

  function automatic int countHoldLow();
    int n = 0;
    for (int i = 1; i <= 20; i++) if (!holdLog[i]) n++;
    return n;
  endfunction

  function automatic int firstPc();
    for (int i = 1; i <= 20; i++) if (pcLog[i]) return i;
    return 0;
  endfunction

  initial begin
    int holdLowTotal;
    int contTotal;

    reset        = 1'b0;
    start_btn    = 1'b0;
    continue_btn = 1'b0;
    ecall        = 1'b0;
    test_sw      = 3'd0;
    repeat (3) @(negedge clock);
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_hold", 32'(pc_hold), 32'd1);
    checkOutput("rst_pcchg", 32'(pc_change), 32'd0);
    checkOutput("rst_cont", 32'(continue_out), 32'd0);
    checkOutput("rst_testnum", 32'(test_number), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // Bounce: start held too briefly to be accepted.
    applyStimulus(1'b1, 1'b0, 2, 0);
    checkOutput("bounce_pc_count", 32'(countPc()), 32'd0);
    checkOutput("bounce_state", 32'(stateLog[20]), 32'd0);

    // Clean start with test 5: raw edge to LOAD takes 2+4+1 cycles plus the FSM edge.
    test_sw = 3'd5;
    repeat (3) @(negedge clock);
    applyStimulus(1'b1, 1'b0, 10, 0);
    checkOutput("start_first_pc", 32'(firstPc()), 32'd8);
    checkOutput("start_pc_count", 32'(countPc()), 32'd1);
    checkOutput("start_load_state", 32'(stateLog[8]), 32'd1);
    checkOutput("start_load_hold", 32'(holdLog[8]), 32'd0);
    checkOutput("start_run_state", 32'(stateLog[9]), 32'd2);
    checkOutput("start_testnum", 32'(test_number), 32'd5);
    checkOutput("run_hold", 32'(pc_hold), 32'(STEP));

    // ecall in RUN, then continue release with ecall still asserted one more cycle.
    ecall = 1'b1;
    @(negedge clock);
    checkOutput("ewait_state", 32'(state), 32'd3);
    checkOutput("ewait_hold", 32'(pc_hold), 32'd1);
    applyStimulus(1'b0, 1'b1, 10, 9);
    checkOutput("cont_count", 32'(countCont()), 32'd1);
    checkOutput("cont_pulse_at8", 32'(contLog[8]), 32'd1);
    checkOutput("cont_state_at8", 32'(stateLog[8]), 32'd2);
    checkOutput("cont_hold_at8", 32'(holdLog[8]), 32'd0);
    checkOutput("cont_no_reenter", 32'(stateLog[9]), 32'd2);
    checkOutput("cont_hold_at9", 32'(holdLog[9]), 32'(STEP));
    checkOutput("cont_end_state", 32'(stateLog[20]), 32'd2);

    // Back into EWAIT, then start and continue together with test 2.
    ecall = 1'b1;
    @(negedge clock);
    ecall = 1'b0;
    checkOutput("ewait2_state", 32'(state), 32'd3);
    test_sw = 3'd2;
    repeat (3) @(negedge clock);
    applyStimulus(1'b1, 1'b1, 10, 0);
    checkOutput("both_load_state", 32'(stateLog[8]), 32'd1);
    checkOutput("both_cont_count", 32'(countCont()), 32'd0);
    checkOutput("both_pc_count", 32'(countPc()), 32'd1);
    checkOutput("both_testnum", 32'(test_number), 32'd2);
    checkOutput("both_end_state", 32'(stateLog[20]), 32'd2);

    // Three continue presses in RUN: discarded when free-running, one step each otherwise.
    test_sw      = 3'd7;
    holdLowTotal = 0;
    contTotal    = 0;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b0, 1'b1, 8, 0);
      holdLowTotal += countHoldLow();
      contTotal    += countCont();
    end
    checkOutput("runcont_holdlow", 32'(holdLowTotal), STEP ? 32'd3 : 32'd60);
    checkOutput("runcont_cont", 32'(contTotal), 32'd0);
    checkOutput("runcont_state", 32'(state), 32'd2);
    checkOutput("runcont_testnum", 32'(test_number), 32'd2);

    // Reset asserted mid-RUN.
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midrst_state", 32'(state), 32'd0);
    checkOutput("midrst_hold", 32'(pc_hold), 32'd1);
    checkOutput("midrst_pcchg", 32'(pc_change), 32'd0);
    checkOutput("midrst_testnum", 32'(test_number), 32'd0);
    checkOutput("midrst_cont", 32'(continue_out), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
